// File: rtl/cpu_commit_mem_ctrl_if.sv
// Commit-stage bundle, data-memory port and writeback bundle for cpu_commit_mem_ctrl.
// The master modport is the controller's view; slave is the surrounding pipeline/memory.
interface cpu_commit_mem_ctrl_if #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 16
);
    localparam int RD_W = $clog2(NUM_REGS);

    // commit bundle from upstream
    logic                 in_valid;
    logic                 in_mem_read;
    logic                 in_mem_write;
    logic                 in_mem_to_reg;
    logic                 in_reg_write;
    logic [REG_WIDTH-1:0] in_alu_result;
    logic [REG_WIDTH-1:0] in_rb_data;
    logic [RD_W-1:0]      in_reg_dest;
    logic                 stall;

    // data-memory port
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [REG_WIDTH-1:0] req_addr;
    logic [REG_WIDTH-1:0] req_wdata;
    logic                 rsp_valid;
    logic [REG_WIDTH-1:0] rsp_data;

    // writeback bundle to the register file
    logic                 wb_valid;
    logic                 wb_reg_write;
    logic [RD_W-1:0]      wb_reg_dest;
    logic [REG_WIDTH-1:0] wb_data;
    logic                 err;

    modport master (
        input  in_valid, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write,
        input  in_alu_result, in_rb_data, in_reg_dest,
        output stall,
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data,
        output wb_valid, wb_reg_write, wb_reg_dest, wb_data, err
    );

    modport slave (
        output in_valid, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write,
        output in_alu_result, in_rb_data, in_reg_dest,
        input  stall,
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data,
        input  wb_valid, wb_reg_write, wb_reg_dest, wb_data, err
    );
endinterface

// File: rtl/cpu_commit_mem_ctrl.sv
// cpu_commit_mem_ctrl: commit-stage sequencer. Issues one load/store at a time on a
// ready/valid memory port, stalls upstream while it is outstanding, produces a
// registered writeback bundle and aborts hung transactions with a sticky error.
module cpu_commit_mem_ctrl #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 16,
    parameter int TIMEOUT   = 255
) (
    input logic                   clk,
    input logic                   rst_n,
    cpu_commit_mem_ctrl_if.master bus
);
    localparam int RD_W  = $clog2(NUM_REGS);
    // one spare bit keeps the replication below legal for the smallest TIMEOUT
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_s;
    logic                 capture_s;
    logic                 stall_s;
    logic                 memop_s;
    logic                 timeout_s;

    // bundle held for the duration of a memory transaction
    logic                 hold_we_r;
    logic                 hold_mem_to_reg_r;
    logic                 hold_reg_write_r;
    logic [REG_WIDTH-1:0] hold_alu_r;
    logic [REG_WIDTH-1:0] hold_rb_r;
    logic [RD_W-1:0]      hold_dest_r;

    logic                 wb_valid_r;
    logic                 wb_valid_s;
    logic                 wb_reg_write_r;
    logic                 wb_reg_write_s;
    logic [RD_W-1:0]      wb_reg_dest_r;
    logic [RD_W-1:0]      wb_reg_dest_s;
    logic [REG_WIDTH-1:0] wb_data_r;
    logic [REG_WIDTH-1:0] wb_data_s;
    logic                 err_r;
    logic                 err_s;

    assign memop_s   = bus.in_valid & (bus.in_mem_read | bus.in_mem_write);
    assign timeout_s = (cnt_r == CNT_LAST);

    // Next-state, stall and writeback decode; completion beats timeout in the same cycle
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        capture_s      = 1'b0;
        stall_s        = 1'b0;
        wb_valid_s     = 1'b0;
        wb_reg_write_s = 1'b0;
        wb_reg_dest_s  = {RD_W{1'b0}};
        wb_data_s      = {REG_WIDTH{1'b0}};
        err_s          = err_r;
        case (state_r)
            ST_IDLE: begin
                if (memop_s) begin
                    capture_s = 1'b1;
                    state_s   = ST_REQ;
                    cnt_s     = CNT_ZERO;
                    stall_s   = 1'b1;
                end else if (bus.in_valid) begin
                    wb_valid_s     = 1'b1;
                    wb_reg_write_s = bus.in_reg_write;
                    wb_reg_dest_s  = bus.in_reg_dest;
                    wb_data_s      = bus.in_alu_result;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.req_ready && hold_we_r) begin
                    state_s        = ST_IDLE;
                    wb_valid_s     = 1'b1;
                    wb_reg_write_s = hold_reg_write_r;
                    wb_reg_dest_s  = hold_dest_r;
                    wb_data_s      = hold_alu_r;
                end else if (timeout_s) begin
                    state_s       = ST_IDLE;
                    wb_valid_s    = 1'b1;
                    wb_reg_dest_s = hold_dest_r;
                    wb_data_s     = hold_alu_r;
                    err_s         = 1'b1;
                end else if (bus.req_ready) begin
                    state_s = ST_WAIT;
                    cnt_s   = cnt_r + CNT_ONE;
                    stall_s = 1'b1;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    stall_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.rsp_valid) begin
                    state_s        = ST_IDLE;
                    wb_valid_s     = 1'b1;
                    wb_reg_write_s = hold_reg_write_r;
                    wb_reg_dest_s  = hold_dest_r;
                    wb_data_s      = hold_mem_to_reg_r ? bus.rsp_data : hold_alu_r;
                end else if (timeout_s) begin
                    state_s       = ST_IDLE;
                    wb_valid_s    = 1'b1;
                    wb_reg_dest_s = hold_dest_r;
                    wb_data_s     = hold_alu_r;
                    err_s         = 1'b1;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and timeout counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Capture the commit bundle when a memory operation is accepted; write wins over read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_we_r         <= 1'b0;
            hold_mem_to_reg_r <= 1'b0;
            hold_reg_write_r  <= 1'b0;
            hold_alu_r        <= {REG_WIDTH{1'b0}};
            hold_rb_r         <= {REG_WIDTH{1'b0}};
            hold_dest_r       <= {RD_W{1'b0}};
        end else if (capture_s) begin
            hold_we_r         <= bus.in_mem_write;
            hold_mem_to_reg_r <= bus.in_mem_to_reg;
            hold_reg_write_r  <= bus.in_reg_write;
            hold_alu_r        <= bus.in_alu_result;
            hold_rb_r         <= bus.in_rb_data;
            hold_dest_r       <= bus.in_reg_dest;
        end
    end

    // Registered writeback bundle and sticky timeout error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_r     <= 1'b0;
            wb_reg_write_r <= 1'b0;
            wb_reg_dest_r  <= {RD_W{1'b0}};
            wb_data_r      <= {REG_WIDTH{1'b0}};
            err_r          <= 1'b0;
        end else begin
            wb_valid_r     <= wb_valid_s;
            wb_reg_write_r <= wb_reg_write_s;
            wb_reg_dest_r  <= wb_reg_dest_s;
            wb_data_r      <= wb_data_s;
            err_r          <= err_s;
        end
    end

    // stall is gated by reset so it drops the moment reset asserts
    assign bus.stall        = rst_n & stall_s;
    assign bus.req_valid    = (state_r == ST_REQ);
    assign bus.req_we       = (state_r == ST_REQ) & hold_we_r;
    assign bus.req_addr     = (state_r == ST_REQ) ? hold_alu_r : {REG_WIDTH{1'b0}};
    assign bus.req_wdata    = (state_r == ST_REQ) ? hold_rb_r  : {REG_WIDTH{1'b0}};
    assign bus.wb_valid     = wb_valid_r;
    assign bus.wb_reg_write = wb_reg_write_r;
    assign bus.wb_reg_dest  = wb_reg_dest_r;
    assign bus.wb_data      = wb_data_r;
    assign bus.err          = err_r;
endmodule

// File: tb/tb_cpu_commit_mem_ctrl.sv
// Directed testbench for cpu_commit_mem_ctrl with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are compared 1 unit later.
module tb_cpu_commit_mem_ctrl;
    localparam int REG_WIDTH = 32;
    localparam int NUM_REGS  = 16;
    localparam int TIMEOUT   = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    cpu_commit_mem_ctrl_if #(.REG_WIDTH(REG_WIDTH), .NUM_REGS(NUM_REGS)) bus ();

    cpu_commit_mem_ctrl #(
        .REG_WIDTH(REG_WIDTH),
        .NUM_REGS (NUM_REGS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid      = 1'b0;
        bus.in_mem_read   = 1'b0;
        bus.in_mem_write  = 1'b0;
        bus.in_mem_to_reg = 1'b0;
        bus.in_reg_write  = 1'b0;
        bus.in_alu_result = 32'h0;
        bus.in_rb_data    = 32'h0;
        bus.in_reg_dest   = 4'h0;
    endtask

    task automatic drive_bundle(input logic rd, input logic wr, input logic m2r, input logic rw,
                                input logic [31:0] alu, input logic [31:0] rb, input logic [3:0] dest);
        bus.in_valid      = 1'b1;
        bus.in_mem_read   = rd;
        bus.in_mem_write  = wr;
        bus.in_mem_to_reg = m2r;
        bus.in_reg_write  = rw;
        bus.in_alu_result = alu;
        bus.in_rb_data    = rb;
        bus.in_reg_dest   = dest;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = 32'h0;
        drive_idle();
        #3;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", bus.stall); end
        checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0h exp=0", bus.req_valid); end
        checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0h exp=0", bus.wb_valid); end
        checks++; if (bus.wb_data !== 32'h0) begin failures++; $display("FAIL reset_wb_data got=%0h exp=0", bus.wb_data); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", bus.err); end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_alu_op();
        drive_bundle(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 4'd5);
        settle();
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL alu_stall_c0 got=%0h exp=0", bus.stall); end
        checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL alu_req_valid got=%0h exp=0", bus.req_valid); end
        next_cycle();
        drive_idle();
        settle();
        checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL alu_wb_valid got=%0h exp=1", bus.wb_valid); end
        checks++; if (bus.wb_reg_dest !== 4'd5) begin failures++; $display("FAIL alu_wb_dest got=%0h exp=5", bus.wb_reg_dest); end
        checks++; if (bus.wb_data !== 32'h1234) begin failures++; $display("FAIL alu_wb_data got=%0h exp=1234", bus.wb_data); end
        checks++; if (bus.wb_reg_write !== 1'b1) begin failures++; $display("FAIL alu_wb_reg_write got=%0h exp=1", bus.wb_reg_write); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL alu_stall_c1 got=%0h exp=0", bus.stall); end
        next_cycle();
        settle();
        checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL alu_wb_pulse got=%0h exp=0", bus.wb_valid); end
    endtask

    task automatic test_store();
        drive_bundle(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'hDEAD, 4'd0);
        bus.req_ready = 1'b0;
        settle();
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL st_stall_c0 got=%0h exp=1", bus.stall); end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            settle();
            checks++; if (bus.req_valid !== 1'b1) begin failures++; $display("FAIL st_req_valid c%0d got=%0h exp=1", c, bus.req_valid); end
            checks++; if (bus.req_addr !== 32'h40) begin failures++; $display("FAIL st_req_addr c%0d got=%0h exp=40", c, bus.req_addr); end
            checks++; if (bus.req_wdata !== 32'hDEAD) begin failures++; $display("FAIL st_req_wdata c%0d got=%0h exp=dead", c, bus.req_wdata); end
            checks++; if (bus.req_we !== 1'b1) begin failures++; $display("FAIL st_req_we c%0d got=%0h exp=1", c, bus.req_we); end
            checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL st_stall c%0d got=%0h exp=1", c, bus.stall); end
            checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL st_wb_early c%0d got=%0h exp=0", c, bus.wb_valid); end
        end
        next_cycle();
        bus.req_ready = 1'b1;
        settle();
        checks++; if (bus.req_valid !== 1'b1) begin failures++; $display("FAIL st_req_valid_c4 got=%0h exp=1", bus.req_valid); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL st_stall_c4 got=%0h exp=0", bus.stall); end
        next_cycle();
        bus.req_ready = 1'b0;
        drive_idle();
        settle();
        checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL st_wb_valid_c5 got=%0h exp=1", bus.wb_valid); end
        checks++; if (bus.wb_reg_write !== 1'b0) begin failures++; $display("FAIL st_wb_reg_write got=%0h exp=0", bus.wb_reg_write); end
        checks++; if (bus.wb_data !== 32'h40) begin failures++; $display("FAIL st_wb_data got=%0h exp=40", bus.wb_data); end
        checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL st_req_drop got=%0h exp=0", bus.req_valid); end
    endtask

    task automatic test_load();
        drive_bundle(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 4'd3);
        settle();
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL ld_stall_c0 got=%0h exp=1", bus.stall); end
        next_cycle();
        bus.req_ready = 1'b1;
        settle();
        checks++; if (bus.req_valid !== 1'b1) begin failures++; $display("FAIL ld_req_valid_c1 got=%0h exp=1", bus.req_valid); end
        checks++; if (bus.req_we !== 1'b0) begin failures++; $display("FAIL ld_req_we got=%0h exp=0", bus.req_we); end
        checks++; if (bus.req_addr !== 32'h80) begin failures++; $display("FAIL ld_req_addr got=%0h exp=80", bus.req_addr); end
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL ld_stall_c1 got=%0h exp=1", bus.stall); end
        for (int c = 2; c <= 3; c++) begin
            next_cycle();
            bus.req_ready = 1'b0;
            settle();
            checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL ld_req_valid c%0d got=%0h exp=0", c, bus.req_valid); end
            checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL ld_stall c%0d got=%0h exp=1", c, bus.stall); end
            checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL ld_wb_early c%0d got=%0h exp=0", c, bus.wb_valid); end
        end
        next_cycle();
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'hCAFE;
        settle();
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL ld_stall_c4 got=%0h exp=0", bus.stall); end
        next_cycle();
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = 32'h0;
        drive_idle();
        settle();
        checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL ld_wb_valid_c5 got=%0h exp=1", bus.wb_valid); end
        checks++; if (bus.wb_reg_dest !== 4'd3) begin failures++; $display("FAIL ld_wb_dest got=%0h exp=3", bus.wb_reg_dest); end
        checks++; if (bus.wb_data !== 32'hCAFE) begin failures++; $display("FAIL ld_wb_data got=%0h exp=cafe", bus.wb_data); end
        checks++; if (bus.wb_reg_write !== 1'b1) begin failures++; $display("FAIL ld_wb_reg_write got=%0h exp=1", bus.wb_reg_write); end
    endtask

    // load with mem_to_reg=0 writes back the ALU value at the minimum latency
    task automatic test_load_alu();
        drive_bundle(1'b1, 1'b0, 1'b0, 1'b1, 32'h90, 32'h0, 4'd9);
        next_cycle();
        bus.req_ready = 1'b1;
        next_cycle();
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'h5555;
        settle();
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL lda_stall_c2 got=%0h exp=0", bus.stall); end
        next_cycle();
        bus.rsp_valid = 1'b0;
        drive_idle();
        settle();
        checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL lda_wb_valid_c3 got=%0h exp=1", bus.wb_valid); end
        checks++; if (bus.wb_data !== 32'h90) begin failures++; $display("FAIL lda_wb_data got=%0h exp=90", bus.wb_data); end
        checks++; if (bus.wb_reg_dest !== 4'd9) begin failures++; $display("FAIL lda_wb_dest got=%0h exp=9", bus.wb_reg_dest); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h1111_0001;
        vals[1] = 32'h2222_0002;
        vals[2] = 32'h3333_0003;
        for (int i = 0; i < 3; i++) begin
            drive_bundle(1'b0, 1'b0, 1'b0, 1'b1, vals[i], 32'h0, 4'(i + 10));
            settle();
            checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL b2b_stall i%0d got=%0h exp=0", i, bus.stall); end
            if (i > 0) begin
                checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL b2b_wb_valid i%0d got=%0h exp=1", i, bus.wb_valid); end
                checks++; if (bus.wb_data !== vals[i-1]) begin failures++; $display("FAIL b2b_wb_data i%0d got=%0h exp=%0h", i, bus.wb_data, vals[i-1]); end
            end
            next_cycle();
        end
        drive_idle();
        settle();
        checks++; if (bus.wb_data !== 32'h3333_0003) begin failures++; $display("FAIL b2b_wb_data_last got=%0h exp=33330003", bus.wb_data); end
        checks++; if (bus.wb_reg_dest !== 4'd12) begin failures++; $display("FAIL b2b_wb_dest_last got=%0h exp=c", bus.wb_reg_dest); end
        next_cycle();
    endtask

    task automatic test_both_rw_and_stray();
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'hBAD0;
        next_cycle();
        settle();
        checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL stray_wb_valid got=%0h exp=0", bus.wb_valid); end
        checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL stray_req_valid got=%0h exp=0", bus.req_valid); end
        bus.rsp_valid = 1'b0;
        drive_bundle(1'b1, 1'b1, 1'b1, 1'b0, 32'hA0, 32'hBEEF, 4'd2);
        next_cycle();
        bus.req_ready = 1'b1;
        settle();
        checks++; if (bus.req_we !== 1'b1) begin failures++; $display("FAIL rw_req_we got=%0h exp=1", bus.req_we); end
        checks++; if (bus.req_wdata !== 32'hBEEF) begin failures++; $display("FAIL rw_req_wdata got=%0h exp=beef", bus.req_wdata); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rw_stall got=%0h exp=0", bus.stall); end
        next_cycle();
        bus.req_ready = 1'b0;
        drive_idle();
        settle();
        checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL rw_wb_valid got=%0h exp=1", bus.wb_valid); end
        checks++; if (bus.wb_data !== 32'hA0) begin failures++; $display("FAIL rw_wb_data got=%0h exp=a0", bus.wb_data); end
        next_cycle();
    endtask

    task automatic test_timeout();
        drive_bundle(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 4'd7);
        next_cycle();
        bus.req_ready = 1'b1;
        next_cycle();
        bus.req_ready = 1'b0;
        for (int c = 2; c <= 7; c++) begin
            settle();
            checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL to_stall c%0d got=%0h exp=1", c, bus.stall); end
            checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL to_err_early c%0d got=%0h exp=0", c, bus.err); end
            next_cycle();
        end
        settle();
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL to_stall_c8 got=%0h exp=0", bus.stall); end
        checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL to_wb_c8 got=%0h exp=0", bus.wb_valid); end
        next_cycle();
        drive_idle();
        settle();
        checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL to_wb_valid_c9 got=%0h exp=1", bus.wb_valid); end
        checks++; if (bus.wb_reg_write !== 1'b0) begin failures++; $display("FAIL to_wb_reg_write got=%0h exp=0", bus.wb_reg_write); end
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL to_err_c9 got=%0h exp=1", bus.err); end
        for (int c = 0; c < 3; c++) next_cycle();
        settle();
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%0h exp=1", bus.err); end
        checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL to_wb_after got=%0h exp=0", bus.wb_valid); end
    endtask

    task automatic test_reset_in_wait();
        next_cycle();
        drive_bundle(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h77, 4'd4);
        next_cycle();
        bus.req_ready = 1'b1;
        next_cycle();
        bus.req_ready = 1'b0;
        next_cycle();
        settle();
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL rw_wait_stall got=%0h exp=1", bus.stall); end
        rst_n = 1'b0;
        settle();
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0h exp=0", bus.stall); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", bus.err); end
        checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%0h exp=0", bus.req_valid); end
        checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb_valid got=%0h exp=0", bus.wb_valid); end
        next_cycle();
        drive_idle();
        rst_n = 1'b1;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'h9999;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            settle();
            checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL rst_no_wb c%0d got=%0h exp=0", c, bus.wb_valid); end
        end
        bus.rsp_valid = 1'b0;
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err_after got=%0h exp=0", bus.err); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_op();
        test_store();
        test_load();
        test_load_alu();
        test_back_to_back();
        test_both_rw_and_stray();
        test_timeout();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_commit_mem_ctrl.md
# cpu_commit_mem_ctrl

Sequencing controller for the commit (memory) stage. It takes the commit-stage bundle (mem control, writeback control, ALU result, store data, destination register) and drives a single ready/valid data-memory port. It stalls the upstream pipeline while a load or store is outstanding and produces a registered writeback bundle for the register file. A timeout counter aborts hung memory transactions and raises a sticky error.

## Interface
Parameters:
- REG_WIDTH, 32, datapath width (matches `REG_WIDTH`)
- NUM_REGS, 16, register count; RD_W = $clog2(NUM_REGS)
- TIMEOUT, 255, max cycles a transaction may spend in REQ+WAIT (≥2)

Ports (clock and reset first):
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  commit bundle valid
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_mem_to_reg  in  1  writeback selects memory data
- in_reg_write  in  1  writeback enable
- in_alu_result  in  REG_WIDTH  address / ALU value
- in_rb_data  in  REG_WIDTH  store data
- in_reg_dest  in  RD_W  destination register
- stall  out  1  upstream must hold its bundle
- req_valid  out  1  memory request valid
- req_ready  in  1  memory accepts request
- req_we  out  1  1 = store, 0 = load
- req_addr  out  REG_WIDTH  request address
- req_wdata  out  REG_WIDTH  store data
- rsp_valid  in  1  load data valid
- rsp_data  in  REG_WIDTH  load data
- wb_valid  out  1  writeback bundle valid (1-cycle pulse per instruction)
- wb_reg_write  out  1  register-file write enable
- wb_reg_dest  out  RD_W  destination
- wb_data  out  REG_WIDTH  write data
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, REQ, WAIT.
- memop = in_valid & (in_mem_read | in_mem_write).
- IDLE, memop: capture all in_* fields into hold registers and go to REQ. If both read and write are set, the operation is a store (write wins).
- IDLE, in_valid & !memop: next cycle wb_valid=1, wb_data=in_alu_result, wb_reg_write=in_reg_write, wb_reg_dest=in_reg_dest.
- REQ: req_valid=1. req_we, req_addr and req_wdata come from the hold registers and stay stable until req_ready.
  - req_ready & store: go to IDLE. Next cycle wb_valid=1 with held reg_write/dest and wb_data=held alu_result.
  - req_ready & load: go to WAIT.
- WAIT: on rsp_valid, go to IDLE. Next cycle wb_valid=1 and wb_data = held mem_to_reg ? rsp_data : held alu_result.
- rsp_valid outside WAIT is ignored.
- stall = (IDLE & memop) | ((REQ | WAIT) & !complete), where complete = store accepted, load response, or timeout. stall is low in the completion cycle so upstream advances at that edge.
- Timeout:
  - Counter clears on entry to REQ and increments every REQ/WAIT cycle.
  - When the counter equals TIMEOUT-1 with no completion, abort: go to IDLE, stall=0, and next cycle wb_valid=1 with wb_reg_write=0 and err=1.
  - Completion in the same cycle takes priority over timeout.
- err clears only on reset.

## Timing
- Reset (async assert, any state): state=IDLE. stall, req_valid, req_we, req_addr, req_wdata, wb_valid, wb_reg_write, wb_reg_dest, wb_data and err all drop to 0 immediately. An in-flight transaction is dropped with no writeback.
- Outputs:
  - req_* and wb_* are registered or decoded from state and hold registers.
  - stall is combinational from state, in_* and req_ready/rsp_valid.
- Latencies (bundle presented at cycle 0):
  - Non-mem: wb_valid at cycle 1.
  - Store with req_ready at cycle 1: wb_valid at cycle 2.
  - Load with req_ready at cycle 1 and rsp_valid at cycle 2: wb_valid at cycle 3.
- Back-to-back non-mem bundles give one writeback per cycle with no stall.
- wb_valid is low in every cycle without a completion.

## Test plan
- ALU op (in_valid=1, reg_write=1, dest=5, alu=0x1234, no mem) -> cycle 1: wb_valid=1, dest=5, data=0x1234, stall=0 throughout.
- Store addr=0x40 data=0xDEAD, req_ready low for 3 cycles -> req_valid held with stable addr/wdata, stall=1; accepted cycle 4, stall=0 that cycle; wb_valid cycle 5 with wb_reg_write=0.
- Load addr=0x80, mem_to_reg=1, dest=3, req_ready cycle 1, rsp_data=0xCAFE at cycle 4 -> wb_valid cycle 5, dest=3, data=0xCAFE; stall high cycles 0–3.
- TIMEOUT=8, load never answered -> abort at counter=7, stall=0 that cycle; next cycle wb_valid=1, wb_reg_write=0, err=1; err stays 1 until rst_n.
- rst_n pulsed low while in WAIT -> all outputs 0 immediately, no wb_valid after release; a stray rsp_valid in IDLE is ignored; a bundle with both read and write set issues req_we=1.
